axi_cmd_sequencer: RTL and testbench
====================================

AXI_CMD_SEQUENCER -- requirements
Module: axi_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 255, max cycles waited for a done pulse.
REQ-003 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-004 SHALL have port arst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1, upstream command offered.
REQ-006 SHALL have port cmd_ready, output, 1, FIFO can accept a command.
REQ-007 SHALL have port cmd_write, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr, input, 32, transaction address.
REQ-009 SHALL have port cmd_wdata, input, 32, write data (ignored for reads).
REQ-010 SHALL have port rsp_valid, output, 1, completion available.
REQ-011 SHALL have port rsp_ready, input, 1, upstream accepts completion.
REQ-012 SHALL have port rsp_write, output, 1, op type of completed command.
REQ-013 SHALL have port rsp_rdata, output, 32, read data (0 for writes/timeouts).
REQ-014 SHALL have port rsp_err, output, 1, completion timed out.
REQ-015 SHALL have ports start_write and start_read, output, 1 each, one-cycle start pulses to the AXI-Lite master top.
REQ-016 SHALL have ports write_data, write_address_M, read_address, output, 32 each, operands to master top.
REQ-017 SHALL have ports read_data (input, 32), write_done and read_done (input, 1 each), results from master top.
REQ-018 SHALL have port fifo_count, output, $clog2(DEPTH)+1, queued-command count.

Function
REQ-019 SHALL push {cmd_write, cmd_addr, cmd_wdata} when cmd_valid && cmd_ready; cmd_ready = (fifo_count < DEPTH), independent of same-cycle pop.
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-021 IDLE: if FIFO non-empty, pop head into working register, go ISSUE next cycle; else stay.
REQ-022 ISSUE: assert exactly one of start_write/start_read for one cycle per working op; clear timeout counter; go WAIT.
REQ-023 write_data, write_address_M, read_address SHALL be driven from the working register and stay stable from ISSUE until leaving WAIT; read_address = write_address_M = cmd_addr.
REQ-024 WAIT: matching done (write_done for writes, read_done for reads) SHALL capture read_data (reads) into rsp_rdata, rsp_err=0, go RESP.
REQ-025 WAIT: non-matching done pulses SHALL be ignored; done pulses in IDLE/ISSUE/RESP SHALL be ignored.
REQ-026 WAIT: counter increments each cycle; on reaching TIMEOUT without matching done, rsp_err=1, rsp_rdata=0, go RESP.
REQ-027 RESP: rsp_valid=1, rsp_* stable until rsp_ready; on handshake go IDLE (no same-cycle re-issue).
REQ-028 Push during any state SHALL be accepted if not full; simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-029 FIFO read/write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-030 Minimum command-to-start latency from push into empty FIFO in IDLE: start pulse 2 cycles after push edge.

Reset
REQ-031 On arst_n low SHALL asynchronously enter IDLE, empty FIFO (pointers, count 0), clear working register and timeout counter.
REQ-032 During/after reset all outputs SHALL be 0 except cmd_ready=1 after deassertion; in-flight command SHALL be discarded with no response.

Structure
REQ-033 Shared package SHALL hold FSM state enum, command-entry struct {write, addr, wdata}, response struct.
REQ-034 FIFO SHALL be a sub-module axi_cmd_fifo (parameter DEPTH, push/pop/full/empty/count).

Verification
REQ-035 Write 0xA5A5_0001 to 0x0000_0010, done after 3 cycles -> one start_write pulse, address/data stable, rsp_write=1, rsp_err=0.
REQ-036 Read 0x10 after REQ-035 -> start_read pulse, read_done with read_data 0xA5A5_0001 -> rsp_rdata=0xA5A5_0001.
REQ-037 Push 5 commands back-to-back with DEPTH=4, master stalled -> 5th held (cmd_ready=0) until first pop; all 5 complete in order.
REQ-038 Read with no done, TIMEOUT=8 -> rsp_err=1, rsp_rdata=0 after 8 WAIT cycles; stray read_done later ignored.
REQ-039 rsp_ready held low 10 cycles -> rsp_valid/rsp_* stable, no new start pulse until handshake.
REQ-040 arst_n asserted in WAIT with 2 queued -> all outputs 0, fifo_count=0, no response after release.

Source files
------------

// File: rtl/axi_cmd_sequencer_pkg.sv
// Shared types for the AXI-Lite command sequencer.
//   seq_state_e : sequencer FSM states
//   cmd_entry_t : one queued command {write, addr, wdata}
//   rsp_entry_t : one completion {write, rdata, err}
package axi_cmd_sequencer_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } seq_state_e;

  typedef struct packed {
    logic             write;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] wdata;
  } cmd_entry_t;

  typedef struct packed {
    logic             write;
    logic [DataW-1:0] rdata;
    logic             err;
  } rsp_entry_t;

endpackage

// File: rtl/axi_cmd_fifo.sv
// Command FIFO for the sequencer.
//   clk_i, arst_ni : clock, asynchronous active-low reset
//   push_i/push_data_i : write an entry (dropped when full)
//   pop_i/pop_data_o   : head entry, advanced on pop (dropped when empty)
//   full_o, empty_o, count_o : occupancy status
module axi_cmd_fifo
  import axi_cmd_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   arst_ni,
  input  logic                   push_i,
  input  cmd_entry_t             push_data_i,
  input  logic                   pop_i,
  output cmd_entry_t             pop_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] DepthCnt = DEPTH[PtrW:0];

  cmd_entry_t      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o     = (count_q == DepthCnt);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointer overflow is the modulo-DEPTH wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/axi_cmd_sequencer.sv
// Queues read/write commands and issues them one at a time to an AXI-Lite
// master, collecting each completion (or a timeout) as a response.
//   clk, arst_n                   : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready + cmd_*   : command input handshake
//   rsp_valid/rsp_ready + rsp_*   : completion output handshake
//   start_write, start_read       : one-cycle start pulses to the master
//   write_data, write_address_M,
//   read_address                  : operands, held from issue to completion
//   read_data, write_done,
//   read_done                     : results from the master
//   fifo_count                    : commands currently queued
module axi_cmd_sequencer
  import axi_cmd_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [31:0]            cmd_addr,
  input  logic [31:0]            cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_write,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic                   start_write,
  output logic                   start_read,
  output logic [31:0]            write_data,
  output logic [31:0]            write_address_M,
  output logic [31:0]            read_address,
  input  logic [31:0]            read_data,
  input  logic                   write_done,
  input  logic                   read_done,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  seq_state_e      state_q, state_d;
  cmd_entry_t      work_q, work_d;
  rsp_entry_t      rsp_q, rsp_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

  cmd_entry_t push_entry;
  cmd_entry_t head_entry;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       fifo_pop;
  logic       done_match;

  assign push_entry = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  // Ready depends only on occupancy, never on a same-cycle pop.
  assign cmd_ready  = !fifo_full;
  assign fifo_push  = cmd_valid && cmd_ready;

  axi_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .arst_ni    (arst_n),
    .push_i     (fifo_push),
    .push_data_i(push_entry),
    .pop_i      (fifo_pop),
    .pop_data_o (head_entry),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    rsp_d       = rsp_q;
    tmo_cnt_d   = tmo_cnt_q;
    fifo_pop    = 1'b0;
    start_write = 1'b0;
    start_read  = 1'b0;
    rsp_valid   = 1'b0;
    // Only the done matching the op in flight counts; the other is noise.
    done_match  = work_q.write ? write_done : read_done;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          work_d   = head_entry;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        start_write = work_q.write;
        start_read  = !work_q.write;
        tmo_cnt_d   = '0;
        state_d     = StWait;
      end
      StWait: begin
        // A done arriving in the last allowed cycle still wins over timeout.
        if (done_match) begin
          rsp_d   = '{write: work_q.write, rdata: work_q.write ? '0 : read_data, err: 1'b0};
          state_d = StResp;
        end else if (tmo_cnt_q == TmoLast) begin
          rsp_d   = '{write: work_q.write, rdata: '0, err: 1'b1};
          state_d = StResp;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= StIdle;
      work_q    <= '0;
      rsp_q     <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      rsp_q     <= rsp_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Operands come straight from the working register, which only reloads in
  // idle, so they hold steady for the whole issue/wait/response window.
  assign write_data      = work_q.wdata;
  assign write_address_M = work_q.addr;
  assign read_address    = work_q.addr;

  assign rsp_write = rsp_q.write;
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_axi_cmd_sequencer.sv
module tb_axi_cmd_sequencer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic                   clk;
  logic                   arst_n;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic                   cmd_write;
  logic [31:0]            cmd_addr;
  logic [31:0]            cmd_wdata;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   rsp_write;
  logic [31:0]            rsp_rdata;
  logic                   rsp_err;
  logic                   start_write;
  logic                   start_read;
  logic [31:0]            write_data;
  logic [31:0]            write_address_M;
  logic [31:0]            read_address;
  logic [31:0]            read_data;
  logic                   write_done;
  logic                   read_done;
  logic [$clog2(DEPTH):0] fifo_count;

  axi_cmd_sequencer #(
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_write      (rsp_write),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .start_write    (start_write),
    .start_read     (start_read),
    .write_data     (write_data),
    .write_address_M(write_address_M),
    .read_address   (read_address),
    .read_data      (read_data),
    .write_done     (write_done),
    .read_done      (read_done),
    .fifo_count     (fifo_count)
  );

  // delay: cycles after the start pulse until the matching done; -1 = never.
  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    int          hold;
    bit          noise;
    bit          stray;
  } tb_cmd_t;

  typedef struct {
    bit          write;
    logic [31:0] rdata;
    bit          err;
    int          lat;
    int          hold;
  } exp_rsp_t;

  tb_cmd_t  exp_start_q[$];
  exp_rsp_t exp_rsp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start_cyc = 0;
  bit m_busy = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_write"}, 32'(rsp_write), 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
    chk({tag, "_start"}, 32'({start_write, start_read}), 0);
    chk({tag, "_write_data"}, write_data, 0);
    chk({tag, "_write_addr"}, write_address_M, 0);
    chk({tag, "_read_addr"}, read_address, 0);
    chk({tag, "_fifo_count"}, 32'(fifo_count), 0);
  endtask

  function automatic tb_cmd_t mk(input bit w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [31:0] r, input int dly, input int hold,
                                 input bit noise, input bit stray);
    tb_cmd_t c;
    c.write = w; c.addr = a; c.wdata = d; c.rdata = r;
    c.delay = dly; c.hold = hold; c.noise = noise; c.stray = stray;
    return c;
  endfunction

  // Offer one command from a negedge; returns at the negedge after acceptance.
  task automatic send(input tb_cmd_t c, output int stalls);
    bit acc;
    exp_rsp_t e;
    stalls = 0;
    acc = 0;
    cmd_valid = 1'b1;
    cmd_write = c.write;
    cmd_addr  = c.addr;
    cmd_wdata = c.wdata;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = cmd_ready;
      @(posedge clk);
      if (acc) begin
        exp_start_q.push_back(c);
        e.write = c.write;
        e.err   = (c.delay < 0);
        e.rdata = (c.write || c.delay < 0) ? 32'h0 : c.rdata;
        e.lat   = (c.delay < 0) ? int'(TIMEOUT) + 1 : c.delay + 1;
        e.hold  = c.hold;
        exp_rsp_q.push_back(e);
      end else begin
        stalls++;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!acc) chk("cmd_accept_timeout", 32'(cmd_ready), 1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (exp_rsp_q.size() == 0 && !rsp_valid && !m_busy) break;
      @(negedge clk);
    end
    chk({tag, "_drained"}, 32'(exp_rsp_q.size()), 0);
  endtask

  // Master model: checks each start pulse against the queued command, then
  // answers with done pulses (plus optional wrong-type or stray pulses).
  initial begin : master
    tb_cmd_t cur;
    int      m_cnt;
    bit      stab_bad;
    m_cnt = 0;
    stab_bad = 0;
    write_done = 1'b0;
    read_done  = 1'b0;
    read_data  = '0;
    forever begin
      @(negedge clk);
      write_done = 1'b0;
      read_done  = 1'b0;
      if (!arst_n) begin
        m_busy = 0;
      end else if (start_write || start_read) begin
        if (exp_start_q.size() == 0) begin
          chk("unexpected_start", 32'({start_write, start_read}), 0);
        end else begin
          cur = exp_start_q.pop_front();
          chk("start_kind", 32'({start_write, start_read}), 32'({cur.write, !cur.write}));
          chk("start_write_addr", write_address_M, cur.addr);
          chk("start_read_addr", read_address, cur.addr);
          if (cur.write) chk("start_wdata", write_data, cur.wdata);
          last_start_cyc = cyc;
          m_busy = 1;
          m_cnt = 0;
          stab_bad = 0;
        end
      end else if (m_busy) begin
        m_cnt++;
        if (write_address_M !== cur.addr || read_address !== cur.addr ||
            (cur.write && write_data !== cur.wdata)) stab_bad = 1;
        if (cur.delay > 0) begin
          if (cur.noise && m_cnt == 1) begin
            if (cur.write) begin
              read_done = 1'b1;
              read_data = 32'hDEAD_BEEF;
            end else begin
              write_done = 1'b1;
            end
          end
          if (m_cnt == cur.delay) begin
            if (cur.write) begin
              write_done = 1'b1;
            end else begin
              read_done = 1'b1;
              read_data = cur.rdata;
            end
            chk("operand_stable", 32'(stab_bad), 0);
            m_busy = 0;
          end
        end else begin
          if (m_cnt == int'(TIMEOUT)) chk("operand_stable_tmo", 32'(stab_bad), 0);
          if (cur.stray && (m_cnt == int'(TIMEOUT) + 1 || m_cnt == int'(TIMEOUT) + 5)) begin
            read_done = 1'b1;
            read_data = 32'hBAD0_BAD0;
          end
          if (m_cnt >= int'(TIMEOUT) + 5) m_busy = 0;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on each new response and drives
  // rsp_ready after the per-command hold time.
  initial begin : monitor
    exp_rsp_t    e;
    bit          prev_v;
    int          hold;
    bit          stab_bad;
    bit          start_bad;
    logic [33:0] snap;
    rsp_ready = 1'b0;
    prev_v = 0;
    hold = 0;
    stab_bad = 0;
    start_bad = 0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        rsp_ready = 1'b0;
        prev_v = 0;
      end else begin
        if (rsp_valid && !prev_v) begin
          stab_bad = 0;
          start_bad = 0;
          snap = {rsp_write, rsp_rdata, rsp_err};
          if (exp_rsp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 0);
            hold = 0;
          end else begin
            e = exp_rsp_q.pop_front();
            chk("rsp_write", 32'(rsp_write), 32'(e.write));
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_latency", 32'(cyc - last_start_cyc), 32'(e.lat));
            hold = e.hold;
          end
        end else if (rsp_valid) begin
          if ({rsp_write, rsp_rdata, rsp_err} !== snap) stab_bad = 1;
        end else if (prev_v) begin
          chk("rsp_stable", 32'(stab_bad), 0);
          chk("no_start_in_resp", 32'(start_bad), 0);
        end
        if (rsp_valid) begin
          if (start_write || start_read) start_bad = 1;
          if (hold == 0) rsp_ready = 1'b1;
          else hold--;
        end else begin
          rsp_ready = 1'b0;
        end
        prev_v = rsp_valid;
      end
    end
  end

  initial begin : stim
    int st;
    int push_cyc;
    int seen;
    int early_stalls;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    arst_n    = 1'b0;
    st = 0;
    seen = 0;
    early_stalls = 0;

    repeat (2) @(negedge clk);
    chk_zero("in_rst");
    arst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_fifo_count", 32'(fifo_count), 0);

    // Write then read back the same address; start follows the push by 2 edges.
    send(mk(1, 32'h10, 32'hA5A5_0001, 0, 3, 0, 0, 0), st);
    push_cyc = cyc;
    wait_drain("wr");
    chk("cmd_to_start", 32'(last_start_cyc - push_cyc), 1);
    send(mk(0, 32'h10, 0, 32'hA5A5_0001, 2, 0, 0, 0), st);
    wait_drain("rd");

    // Wrong-type done pulses while waiting must be ignored.
    send(mk(1, 32'h20, 32'h0000_1234, 0, 4, 1, 1, 0), st);
    send(mk(0, 32'h24, 0, 32'hCAFE_F00D, 5, 0, 1, 0), st);
    wait_drain("noise");

    // Fastest done, and a done landing in the very last cycle before timeout.
    send(mk(0, 32'h28, 0, 32'h0BAD_CAFE, 1, 0, 0, 0), st);
    send(mk(0, 32'h2C, 0, 32'h1357_9BDF, int'(TIMEOUT), 2, 0, 0), st);
    wait_drain("edge");

    // No done at all: timeout response, then stray read_done pulses.
    send(mk(0, 32'h30, 0, 32'hFFFF_FFFF, -1, 3, 0, 1), st);
    wait_drain("tmo");

    // Long response stall while the FIFO fills; sixth offer must be held.
    send(mk(1, 32'h40, 32'h0000_0040, 0, 2, 10, 0, 0), st);
    send(mk(0, 32'h44, 0, 32'h4444_0001, 1, 0, 0, 0), st);
    early_stalls += st;
    send(mk(1, 32'h48, 32'h4848_4848, 0, 3, 0, 0, 0), st);
    early_stalls += st;
    send(mk(0, 32'h4C, 0, 32'h4C4C_0003, 2, 1, 0, 0), st);
    early_stalls += st;
    send(mk(1, 32'h50, 32'h5050_5050, 0, 1, 0, 0, 0), st);
    early_stalls += st;
    chk("fill_no_stall", 32'(early_stalls), 0);
    chk("full_count", 32'(fifo_count), DEPTH);
    chk("full_cmd_ready", 32'(cmd_ready), 0);
    send(mk(0, 32'h54, 0, 32'h5454_0005, 3, 0, 0, 0), st);
    chk("fifth_held", 32'(st > 0), 1);
    wait_drain("fill");

    // Reset while waiting with two commands queued: everything is discarded.
    send(mk(0, 32'h60, 0, 32'h6060_6060, -1, 0, 0, 0), st);
    send(mk(1, 32'h64, 32'h6464_6464, 0, 1, 0, 0, 0), st);
    send(mk(0, 32'h68, 0, 32'h6868_6868, 1, 0, 0, 0), st);
    chk("pre_rst_count", 32'(fifo_count), 2);
    chk("pre_rst_addr", read_address, 32'h60);
    #2;
    arst_n = 1'b0;
    #1;
    chk_zero("arst");
    exp_start_q.delete();
    exp_rsp_q.delete();
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("post_rst_fifo_count", 32'(fifo_count), 0);
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid || start_write || start_read) seen++;
    end
    chk("post_rst_quiet", 32'(seen), 0);

    // Normal operation resumes after reset.
    send(mk(0, 32'h70, 0, 32'h7070_0007, 2, 0, 0, 0), st);
    wait_drain("resume");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
